ula_seq: RTL
============

Name: ula_seq

Overview:
- Initiator/controller for the 4-bit ALU (ula). Accepts wide operations over a valid/ready request channel and slices them into 4-bit nibbles.
- Issues one nibble per cycle to an external ula instance, chaining carry between nibbles, and assembles the wide result.
- Returns the result on a valid/ready response channel. Sits between the datapath/sequencer and the ula instance.

Parameters:
- NIBBLES, 2, number of 4-bit slices per operand; W = 4*NIBBLES (default 8-bit), NIBBLES >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready at rising clk
- req_op  in  3  opcode: 000 AND, 001 OR, 010 NOT(A), 011 NAND, 100 ADD, 101 SUB, 110/111 invalid
- req_a  in  W  operand A
- req_b  in  W  operand B
- req_cin  in  1  carry-in for ADD (ignored otherwise)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_res  out  W  result
- rsp_cout  out  1  final carry (ADD carry-out; SUB 1 = no borrow; 0 for logic ops)
- rsp_err  out  1  invalid opcode flag
- alu_a  out  4  to ula A
- alu_b  out  4  to ula B
- alu_sel  out  3  to ula seletor
- alu_cin  out  1  to ula C_in
- alu_res  in  4  from ula resultado
- alu_cout  in  1  from ula C_out

Behaviour:
- Single clock domain clk. rst is asynchronous, active-high. On rst: state IDLE; rsp_valid=0, rsp_res=0, rsp_cout=0, rsp_err=0, nibble index=0, carry reg=0, operand regs=0.
- req_ready = (state==IDLE) & ~rst. It is combinational; no other path.
- FSM:
  - IDLE: on accept, register op/a/b/cin and set idx=0. Carry reg = req_cin for ADD, 1 for SUB, 0 otherwise. Go to EXEC.
  - EXEC: drive the ALU with nibble idx. Each clk edge writes alu_res into result bits [4*idx+3:4*idx] and alu_cout into the carry reg, then increments idx. After the edge that captures idx==NIBBLES-1, go to RESP.
  - RESP: rsp_valid=1. Outputs are stable until the rsp_ready handshake, after which the FSM returns to IDLE.
- Latency: rsp_valid rises exactly NIBBLES cycles after the accept edge. Minimum request-to-request spacing is NIBBLES+2 cycles; there is no request overlap.
- ALU drive in EXEC:
  - alu_a = A nibble.
  - alu_b = B nibble for AND/OR/NAND/ADD; ~B nibble for SUB; 0 for NOT.
  - alu_sel = 100 for ADD and SUB (SUB uses two's complement via ADD); otherwise alu_sel = req_op.
  - alu_cin = carry reg for ADD/SUB, 0 otherwise.
- ALU drive in IDLE/RESP: alu_a=0, alu_b=0, alu_sel=000, alu_cin=0.
- Carry: final carry reg goes to rsp_cout for ADD/SUB. For logic ops rsp_cout=0 and intermediate alu_cout is ignored.
- Invalid op (110/111): still runs NIBBLES EXEC cycles for uniform latency, with alu_sel=req_op. Result is forced to 0, rsp_err=1, rsp_cout=0. rsp_err=0 for valid ops.
- req_valid while not IDLE: ignored (req_ready=0). The requester must hold its request stable until the handshake.
- rsp_ready high in IDLE/EXEC: no effect.
- rst mid-EXEC or mid-RESP: abort, no response issued, all regs at reset values. The first cycle after release is IDLE.
- Width rules: all arithmetic is modulo 2^W plus carry. A ripple through all nibbles is handled by the registered carry chain, never combinationally across nibbles.

Decomposition:
- Package ula_pkg holds:
  - opcode constants OP_AND, OP_OR, OP_NOT, OP_NAND, OP_ADD, OP_SUB (3-bit), shared with ula users;
  - FSM state encoding IDLE/EXEC/RESP;
  - nibble width constant NIB_W=4.
- One natural sub-module: ula_seq_slice (combinational). Inputs are the registered operands, idx and op. Outputs are alu_a/alu_b/alu_sel/alu_cin, covering nibble select and B inversion. The FSM and result assembly stay in ula_seq.

Test Plan:
- All tests use NIBBLES=2, with a real ula instance wired to the alu_* ports.
- ADD A=0x3C B=0x25 cin=0 -> rsp_res=0x61, rsp_cout=0, rsp_err=0. rsp_valid arrives 2 cycles after the accept edge; alu_cin=1 on the second nibble.
- ADD A=0xFF B=0x01 cin=1 -> rsp_res=0x01, rsp_cout=1.
- SUB A=0x50 B=0x21 -> rsp_res=0x2F, rsp_cout=1. SUB A=0x10 B=0x20 -> rsp_res=0xF0, rsp_cout=0. req_cin=1 has no effect.
- NAND A=0xF0 B=0xCC -> 0x3F, cout=0. NOT A=0xA5 -> 0x5A with alu_b=0 on both nibbles. OR 0x0F|0x30 -> 0x3F.
- Invalid op 110 A=0xFF B=0xFF -> rsp_res=0x00, rsp_err=1, cout=0. Hold rsp_ready=0 for 5 cycles: rsp_* stays stable and req_ready stays 0; the new request is accepted only after the handshake.
- Assert rst for 1 cycle after the first EXEC edge of ADD 0x99+0x99 -> no rsp_valid, all outputs 0. A following ADD 0x12+0x34 returns 0x46, cout=0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the 4-bit ALU (ula) and its wide-operation sequencer.
package ula_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ADD and SUB both run through the ALU adder and use the carry chain.
  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcodes 110/111 have no defined meaning.
  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/ula_seq_slice.sv
// Combinational ALU drive: picks the current operand nibble and maps the
// wide opcode onto the 4-bit ALU controls (SUB = ADD of inverted B).
module ula_seq_slice
  import ula_pkg::*;
#(
  parameter  int unsigned NIBBLES = 2,
  parameter  int unsigned IDX_W   = 1,
  localparam int unsigned W       = NIB_W * NIBBLES
) (
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [IDX_W-1:0] idx,
  input  logic             carry,
  output logic [NIB_W-1:0] alu_a,
  output logic [NIB_W-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_cin
);

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;

  // Nibble select plus opcode mapping; all controls idle at zero when disabled.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = OP_AND;
    alu_cin = 1'b0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a[i*NIB_W +: NIB_W];
        b_nib = b[i*NIB_W +: NIB_W];
      end
    end
    if (en) begin
      alu_a = a_nib;
      case (op)
        OP_SUB:  alu_b = ~b_nib;
        OP_NOT:  alu_b = '0;
        default: alu_b = b_nib;
      endcase
      alu_sel = op_arith(op) ? OP_ADD : op;
      alu_cin = op_arith(op) ? carry : 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Wide-operation sequencer for the 4-bit ALU: accepts a request, issues one
// nibble per cycle with a registered carry chain, and returns the result.
module ula_seq
  import ula_pkg::*;
#(
  parameter  int unsigned NIBBLES = 2,
  localparam int unsigned W       = NIB_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_res,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [NIB_W-1:0] alu_a,
  output logic [NIB_W-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_cin,
  input  logic [NIB_W-1:0] alu_res,
  input  logic             alu_cout
);

  localparam int unsigned      IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  assign rsp_valid = (state == RESP);
  assign rsp_res   = res_q;
  assign rsp_cout  = op_arith(op_q) & carry_q;
  assign rsp_err   = ~op_valid(op_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (idx_q == LAST) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept; per-nibble result and carry capture in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            idx_q   <= '0;
            carry_q <= (req_op == OP_ADD) ? req_cin : (req_op == OP_SUB);
          end
        end
        EXEC: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i))
              res_q[i*NIB_W +: NIB_W] <= op_valid(op_q) ? alu_res : '0;
          end
          carry_q <= alu_cout;
          idx_q   <= (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  ula_seq_slice #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_slice (
    .en      (state == EXEC),
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .idx     (idx_q),
    .carry   (carry_q),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_cin (alu_cin)
  );

endmodule
